// File: rtl/window_gen_5x5.sv
// 5x5 sliding-window generator over a raster pixel stream.
// Ports: i_clk, i_rstn, i_pixel/i_pixel_valid/i_sof in; 200b window, valid, frame_done out.
module window_gen_5x5 #(
  parameter int IMG_WIDTH  = 512,
  parameter int IMG_HEIGHT = 512,
  parameter int COL_W      = $clog2(IMG_WIDTH),
  parameter int ROW_W      = $clog2(IMG_HEIGHT)
) (
  input  logic         i_clk,
  input  logic         i_rstn,
  input  logic [7:0]   i_pixel,
  input  logic         i_pixel_valid,
  input  logic         i_sof,
  output logic [199:0] o_pixel_data,
  output logic         o_pixel_data_valid,
  output logic         o_frame_done
);

  logic [COL_W-1:0] col, col_c, col_n;
  logic [ROW_W-1:0] row, row_c, row_n;
  logic             last_col, last_row;
  logic             in_win, fr_end;

  logic [7:0] lb0 [IMG_WIDTH];
  logic [7:0] lb1 [IMG_WIDTH];
  logic [7:0] lb2 [IMG_WIDTH];
  logic [7:0] lb3 [IMG_WIDTH];

  logic [7:0] win  [5][5];
  logic [7:0] ncol [5];

  // sof re-anchors the pixel to (0,0) before any wrap logic
  always_comb begin
    col_c    = i_sof ? '0 : col;
    row_c    = i_sof ? '0 : row;
    last_col = (col_c == COL_W'(IMG_WIDTH - 1));
    last_row = (row_c == ROW_W'(IMG_HEIGHT - 1));
    col_n    = last_col ? '0 : col_c + COL_W'(1);
    row_n    = row_c;
    if (last_col)
      row_n = last_row ? '0 : row_c + ROW_W'(1);
    // col >= 4 keeps windows from straddling rows;
    // row >= 4 keeps stale line data out after sof
    in_win   = (row_c >= ROW_W'(4)) && (col_c >= COL_W'(4));
    fr_end   = last_col && last_row && !i_sof;
  end

  always_comb begin
    ncol[0] = lb0[col_c];
    ncol[1] = lb1[col_c];
    ncol[2] = lb2[col_c];
    ncol[3] = lb3[col_c];
    ncol[4] = i_pixel;
  end

  always_ff @(posedge i_clk) begin
    if (i_pixel_valid) begin
      lb0[col_c] <= lb1[col_c];
      lb1[col_c] <= lb2[col_c];
      lb2[col_c] <= lb3[col_c];
      lb3[col_c] <= i_pixel;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      col                <= '0;
      row                <= '0;
      o_pixel_data_valid <= 1'b0;
      o_frame_done       <= 1'b0;
      for (int r = 0; r < 5; r++)
        for (int c = 0; c < 5; c++)
          win[r][c] <= '0;
    end else begin
      o_pixel_data_valid <= 1'b0;
      o_frame_done       <= 1'b0;
      if (i_pixel_valid) begin
        col                <= col_n;
        row                <= row_n;
        o_pixel_data_valid <= in_win;
        o_frame_done       <= fr_end;
        for (int r = 0; r < 5; r++) begin
          for (int c = 0; c < 4; c++)
            win[r][c] <= win[r][c+1];
          win[r][4] <= ncol[r];
        end
      end
    end
  end

  always_comb begin
    o_pixel_data = '0;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        o_pixel_data[8*(r*5+c) +: 8] = win[r][c];
  end

endmodule

// File: tb/tb_window_gen_5x5.sv
// Scoreboard bench for window_gen_5x5 on an 8x8 image.
// Pixel value = row*16+col of its frame position.
module tb_window_gen_5x5;

  localparam int W = 8;
  localparam int H = 8;

  logic         i_clk = 0;
  logic         i_rstn = 0;
  logic [7:0]   i_pixel = 0;
  logic         i_pixel_valid = 0;
  logic         i_sof = 0;
  logic [199:0] o_pixel_data;
  logic         o_pixel_data_valid;
  logic         o_frame_done;

  window_gen_5x5 #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .i_clk(i_clk),
    .i_rstn(i_rstn),
    .i_pixel(i_pixel),
    .i_pixel_valid(i_pixel_valid),
    .i_sof(i_sof),
    .o_pixel_data(o_pixel_data),
    .o_pixel_data_valid(o_pixel_data_valid),
    .o_frame_done(o_frame_done)
  );

  always #5 i_clk = ~i_clk;

  int nchk = 0;
  int nerr = 0;

  logic [199:0] exp_q [$];
  logic         done_q [$];

  int br = 0;
  int bc = 0;

  int nwin = 0;
  int ndone = 0;
  logic [199:0] first_win, last_win;
  logic [199:0] last_data = '0;
  logic         last_done_win;
  logic         acc_prev;
  logic [199:0] f1_first;

  task automatic check(input string tag,
                       input logic [199:0] got,
                       input logic [199:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pv(input int r, input int c);
    return 8'(r * 16 + c);
  endfunction

  function automatic logic [199:0] mk_win(input int r, input int c);
    logic [199:0] w;
    w = '0;
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++)
        w[8*(i*5+j) +: 8] = pv(r - 4 + i, c - 4 + j);
    return w;
  endfunction

  always @(posedge i_clk or negedge i_rstn)
    if (!i_rstn) acc_prev <= 1'b0;
    else         acc_prev <= i_pixel_valid;

  always @(negedge i_clk) begin
    if (!i_rstn) begin
      last_data = '0;
    end else begin
      if (o_pixel_data_valid) begin
        check("vld_after_acc", 200'(acc_prev), 200'(1));
        if (exp_q.size() == 0) begin
          check("unexp_vld", 200'(1), 200'(0));
        end else begin
          check("win_data", o_pixel_data, exp_q.pop_front());
          check("win_done", 200'(o_frame_done),
                200'(done_q.pop_front()));
        end
        if (nwin == 0) first_win = o_pixel_data;
        last_win = o_pixel_data;
        last_done_win = o_frame_done;
        nwin++;
      end else begin
        if (o_frame_done)
          check("done_no_vld", 200'(1), 200'(0));
        if (!acc_prev)
          check("gap_stable", o_pixel_data, last_data);
      end
      if (o_frame_done) ndone++;
      last_data = o_pixel_data;
    end
  end

  task automatic drive(input logic sof, input bit gap);
    int r, c;
    @(posedge i_clk); #1;
    if (sof) begin br = 0; bc = 0; end
    r = br; c = bc;
    i_pixel = pv(r, c);
    i_pixel_valid = 1'b1;
    i_sof = sof;
    if (r >= 4 && c >= 4) begin
      exp_q.push_back(mk_win(r, c));
      done_q.push_back(r == H-1 && c == W-1);
    end
    bc++;
    if (bc == W) begin
      bc = 0;
      br++;
      if (br == H) br = 0;
    end
    if (gap) begin
      @(posedge i_clk); #1;
      i_pixel_valid = 1'b0;
      i_sof = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge i_clk); #1;
      i_pixel_valid = 1'b0;
      i_sof = 1'b0;
    end
  endtask

  task automatic frame(input logic sof, input bit gap);
    for (int k = 0; k < W*H; k++)
      drive(sof && k == 0, gap);
  endtask

  initial begin
    #23 i_rstn = 1'b1;
    #1;
    check("rst_data", o_pixel_data, '0);
    check("rst_vld", 200'(o_pixel_data_valid), 200'(0));
    check("rst_done", 200'(o_frame_done), 200'(0));

    nwin = 0; ndone = 0;
    frame(1'b0, 1'b0);
    idle(4);
    check("s1_nwin", 200'(nwin), 200'(16));
    check("s1_ndone", 200'(ndone), 200'(1));
    check("s1_b0", 200'(first_win[7:0]), 200'(8'h00));
    check("s1_b12", 200'(first_win[103:96]), 200'(8'h22));
    check("s1_b24", 200'(first_win[199:192]), 200'(8'h44));
    check("s1_lb0", 200'(last_win[7:0]), 200'(8'h33));
    check("s1_lb24", 200'(last_win[199:192]), 200'(8'h77));
    check("s1_ldone", 200'(last_done_win), 200'(1));
    f1_first = first_win;

    nwin = 0; ndone = 0;
    frame(1'b0, 1'b1);
    idle(4);
    check("s2_nwin", 200'(nwin), 200'(16));
    check("s2_ndone", 200'(ndone), 200'(1));
    check("s2_first", first_win, f1_first);

    nwin = 0; ndone = 0;
    frame(1'b1, 1'b0);
    f1_first = first_win;
    frame(1'b1, 1'b0);
    idle(4);
    check("s3_nwin", 200'(nwin), 200'(32));
    check("s3_ndone", 200'(ndone), 200'(2));
    check("s3_f2first", first_win, mk_win(4, 4));

    nwin = 0; ndone = 0;
    drive(1'b1, 1'b0);
    while (!(br == 2 && bc == 3)) drive(1'b0, 1'b0);
    frame(1'b1, 1'b0);
    idle(4);
    check("s4_nwin", 200'(nwin), 200'(16));
    check("s4_ndone", 200'(ndone), 200'(1));
    check("s4_b0", 200'(first_win[7:0]), 200'(8'h00));

    drive(1'b1, 1'b0);
    while (!(br == 5 && bc == 5)) drive(1'b0, 1'b0);
    @(posedge i_clk); #1;
    i_pixel_valid = 1'b0;
    check("s5_pre_vld", 200'(o_pixel_data_valid), 200'(1));
    #1 i_rstn = 1'b0;
    #1;
    check("s5_rst_vld", 200'(o_pixel_data_valid), 200'(0));
    check("s5_rst_data", o_pixel_data, '0);
    exp_q.delete();
    done_q.delete();
    br = 0; bc = 0;
    idle(2);
    i_rstn = 1'b1;
    nwin = 0; ndone = 0;
    frame(1'b0, 1'b0);
    idle(4);
    check("s5_nwin", 200'(nwin), 200'(16));
    check("s5_ndone", 200'(ndone), 200'(1));
    check("s5_first", first_win, mk_win(4, 4));
    check("q_empty", 200'(exp_q.size()), 200'(0));

    $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule

// File: doc/window_gen_5x5.md
Name: window_gen_5x5

Overview:
Raster-scan pixel streamer and 5x5 window generator that feeds the 5x5 convolution core. It accepts one 8-bit pixel per valid cycle and stores the previous four image rows in line buffers. It emits a full 25-pixel window (200 bits) with a valid strobe whenever a complete, in-image 5x5 neighbourhood exists. It is the producer end of the convolution core's i_pixel_data / i_pixel_data_valid interface, which has no back-pressure.

Parameters:
IMG_WIDTH, 512, pixels per image row; must be >= 5.
IMG_HEIGHT, 512, rows per frame; must be >= 5.
COL_W, $clog2(IMG_WIDTH), column counter width.
ROW_W, $clog2(IMG_HEIGHT), row counter width.

Ports:
i_clk  input  1  clock; all logic rising-edge.
i_rstn  input  1  reset; asynchronous assert, active-low.
i_pixel  input  8  incoming pixel, raster order (left to right, top to bottom).
i_pixel_valid  input  1  i_pixel accepted this cycle when 1.
i_sof  input  1  start of frame; qualified by i_pixel_valid.
o_pixel_data  output  200  5x5 window; byte k = bits [8k+7:8k], k = r*5 + c.
o_pixel_data_valid  output  1  o_pixel_data holds a valid window this cycle.
o_frame_done  output  1  one-cycle pulse after the last pixel of a frame.

Behaviour:
- Reset (i_rstn=0, asynchronous): col/row counters = 0; window registers = 0; o_pixel_data = 0; o_pixel_data_valid = 0; o_frame_done = 0. Line-buffer RAM contents are not reset.
- Accept: a pixel is accepted only on cycles with i_pixel_valid=1. Cycles with i_pixel_valid=0 change nothing except that the valid and done strobes drop to 0.
- Position (row, col) of an accepted pixel:
  - i_sof=1 forces (0,0).
  - Otherwise the pixel takes the current counters.
  - After acceptance, col increments. At IMG_WIDTH-1, col wraps to 0 and row increments.
  - At (IMG_HEIGHT-1, IMG_WIDTH-1), both counters wrap to 0.
  - i_sof overrides any wrap in the same cycle.
- Line buffers LB0..LB3: each IMG_WIDTH x 8, addressed by col. LB0 holds row-4 and LB3 holds row-1. On accept at column c:
  - The new window column is {LB0[c], LB1[c], LB2[c], LB3[c], i_pixel}, for window rows r = 0..4.
  - LB0[c] <= LB1[c], LB1[c] <= LB2[c], LB2[c] <= LB3[c], LB3[c] <= i_pixel.
  - Read-before-write within the same cycle.
- Window shift: window columns 0..3 <= columns 1..4, and column 4 <= the new column. Window row 0 is the oldest (top) row; column 0 is the oldest (left) column.
- Output register: on accept, o_pixel_data <= the shifted window. o_pixel_data holds its value on non-accept cycles.
- Valid: o_pixel_data_valid = 1 exactly one cycle after accepting a pixel with row >= 4 and col >= 4. Latency is 1 cycle from the accepting edge.
- Window content: for a window centred at (row-2, col-2), byte r*5+c = pixel at (row-4+r, col-4+c).
- Window count: exactly (IMG_HEIGHT-4)*(IMG_WIDTH-4) valid windows per frame. Windows with col < 4 straddle rows and are never flagged valid.
- o_frame_done: 1 for one cycle after accepting the pixel at (IMG_HEIGHT-1, IMG_WIDTH-1), coincident with the last window valid. It is suppressed if i_sof was asserted on that same pixel.
- i_sof mid-frame: the partial frame is abandoned with no frame_done. The next valid window appears only after the new frame's (4,4) pixel. Stale line-buffer data is never output as valid.
- Reset mid-frame: outputs clear immediately. After release, the first accepted pixel is (0,0).

Test Plan:
All scenarios use IMG_WIDTH=8, IMG_HEIGHT=8, pixel value = row*16+col.
1. Full frame, i_pixel_valid held 1:
   - Exactly 16 valid windows and 1 frame_done.
   - First valid one cycle after accepting 0x44: byte0=0x00, byte12=0x22, byte24=0x44.
   - Last window: byte0=0x33, byte24=0x77; frame_done high in the same cycle.
2. Same frame with i_pixel_valid toggling 1,0,1,0:
   - Identical 16 windows in identical order.
   - Each valid lasts one cycle, only on the cycle after an accept; o_pixel_data is stable during gaps.
3. Two back-to-back frames, i_sof on the first pixel of each:
   - 32 windows and 2 frame_done pulses.
   - No valid during frame 2 rows 0-3.
   - Frame 2's first window equals frame 1's first window.
4. i_sof at frame position (2,3), then a full frame:
   - No window is output from the abandoned rows and no frame_done for the partial frame.
   - The next valid follows the new (4,4) pixel with byte0=0x00.
5. Assert i_rstn=0 asynchronously mid-row 5:
   - o_pixel_data_valid=0 and o_pixel_data=0 before the next clock edge.
   - After release plus a full frame, 16 windows match scenario 1.
